ctrl_pipeline: RTL and testbench

Receive-side counterpart of the main opcode decoder. Accepts the decoded EX/M/WB/ALUop bundles in ID and carries them through the ID/EX, EX/MEM and MEM/WB pipeline registers. Performs load-use hazard detection, branch and jump flushing, and forwarding-select generation. Sits between the decoder and the datapath stage registers of the 5-stage MIPS-32 core.

---
 rtl/ctrl_pipeline.sv | 164 ++++++++++++++++
 tb/tb_ctrl_pipeline.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/ctrl_pipeline.sv
// ctrl_pipeline
//   Carries decoded control bundles of the 5-stage MIPS-32 core through the
//   ID/EX, EX/MEM and MEM/WB registers, and generates load-use stall,
//   branch/jump flush and ALU operand forwarding selects.
//
// Ports
//   clk, rst                 clock (rising edge), async active-high reset
//   id_ex/id_m/id_wb/id_aluop decoder bundles for the instruction in ID
//   id_rs/id_rt/id_rd         register fields of the instruction in ID
//   ex_zero                   ALU zero flag, captured with EX/MEM
//   ex_ctrl/ex_aluop          ID/EX control outputs
//   fwd_a/fwd_b               operand selects: 10 EX/MEM, 01 MEM/WB, 00 regfile
//   mem_ctrl/pc_src           EX/MEM control, branch taken
//   wb_ctrl/wb_dest           MEM/WB control and destination register
//   stall/flush               hazard controls for PC and IF/ID
module ctrl_pipeline #(
   parameter int RA_W  = 5,
   parameter int AOP_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [1:0]       id_ex,
   input  logic [2:0]       id_m,
   input  logic [2:0]       id_wb,
   input  logic [AOP_W-1:0] id_aluop,
   input  logic [RA_W-1:0]  id_rs,
   input  logic [RA_W-1:0]  id_rt,
   input  logic [RA_W-1:0]  id_rd,
   input  logic             ex_zero,
   output logic [1:0]       ex_ctrl,
   output logic [AOP_W-1:0] ex_aluop,
   output logic [1:0]       fwd_a,
   output logic [1:0]       fwd_b,
   output logic [2:0]       mem_ctrl,
   output logic             pc_src,
   output logic [2:0]       wb_ctrl,
   output logic [RA_W-1:0]  wb_dest,
   output logic             stall,
   output logic             flush
);

   // ID/EX
   logic [1:0]       idex_ex_q,  idex_ex_d;
   logic [2:0]       idex_m_q,   idex_m_d;
   logic [2:0]       idex_wb_q,  idex_wb_d;
   logic [AOP_W-1:0] idex_aop_q, idex_aop_d;
   logic [RA_W-1:0]  idex_rs_q,  idex_rs_d;
   logic [RA_W-1:0]  idex_rt_q,  idex_rt_d;
   logic [RA_W-1:0]  idex_rd_q,  idex_rd_d;
   // EX/MEM
   logic [2:0]       exm_m_q,    exm_m_d;
   logic [2:0]       exm_wb_q,   exm_wb_d;
   logic [RA_W-1:0]  exm_dest_q, exm_dest_d;
   logic             exm_zero_q, exm_zero_d;
   // MEM/WB
   logic [2:0]       mwb_wb_q,   mwb_wb_d;
   logic [RA_W-1:0]  mwb_dest_q, mwb_dest_d;

   logic jump, branch_taken, load_use;
   logic [RA_W-1:0] ex_dest;

   // bundle bit positions: EX {ALUSRC,REGDST}, M {BRANCH,MEMWRITE,MEMREAD},
   // WB {JUMP,REGWRITE,MEMREG}
   assign jump         = mwb_wb_q[2];
   assign branch_taken = exm_m_q[2] & exm_zero_q;
   assign load_use     = idex_m_q[0] && (idex_rt_q != '0) &&
                         ((idex_rt_q == id_rs) || (idex_rt_q == id_rt));
   assign ex_dest      = idex_ex_q[0] ? idex_rd_q : idex_rt_q;

   assign flush  = jump | branch_taken;
   assign stall  = load_use & ~flush;
   assign pc_src = branch_taken;

   always_comb begin
      // ID/EX: bubble on any flush or load-use stall
      idex_ex_d  = '0;
      idex_m_d   = '0;
      idex_wb_d  = '0;
      idex_aop_d = '0;
      idex_rs_d  = '0;
      idex_rt_d  = '0;
      idex_rd_d  = '0;
      if (!flush && !load_use) begin
         idex_ex_d  = id_ex;
         idex_m_d   = id_m;
         idex_wb_d  = id_wb;
         idex_aop_d = id_aluop;
         idex_rs_d  = id_rs;
         idex_rt_d  = id_rt;
         idex_rd_d  = id_rd;
      end
      // EX/MEM: bubble on branch or jump flush
      exm_m_d    = '0;
      exm_wb_d   = '0;
      exm_dest_d = '0;
      exm_zero_d = 1'b0;
      if (!flush) begin
         exm_m_d    = idex_m_q;
         exm_wb_d   = idex_wb_q;
         exm_dest_d = ex_dest;
         exm_zero_d = ex_zero;
      end
      // MEM/WB: only a jump kills it
      mwb_wb_d   = '0;
      mwb_dest_d = '0;
      if (!jump) begin
         mwb_wb_d   = exm_wb_q;
         mwb_dest_d = exm_dest_q;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idex_ex_q  <= '0;
         idex_m_q   <= '0;
         idex_wb_q  <= '0;
         idex_aop_q <= '0;
         idex_rs_q  <= '0;
         idex_rt_q  <= '0;
         idex_rd_q  <= '0;
         exm_m_q    <= '0;
         exm_wb_q   <= '0;
         exm_dest_q <= '0;
         exm_zero_q <= 1'b0;
         mwb_wb_q   <= '0;
         mwb_dest_q <= '0;
      end else begin
         idex_ex_q  <= idex_ex_d;
         idex_m_q   <= idex_m_d;
         idex_wb_q  <= idex_wb_d;
         idex_aop_q <= idex_aop_d;
         idex_rs_q  <= idex_rs_d;
         idex_rt_q  <= idex_rt_d;
         idex_rd_q  <= idex_rd_d;
         exm_m_q    <= exm_m_d;
         exm_wb_q   <= exm_wb_d;
         exm_dest_q <= exm_dest_d;
         exm_zero_q <= exm_zero_d;
         mwb_wb_q   <= mwb_wb_d;
         mwb_dest_q <= mwb_dest_d;
      end
   end

   // Forwarding: the younger EX/MEM result wins over MEM/WB; $0 never forwards
   always_comb begin
      fwd_a = 2'b00;
      if (exm_wb_q[1] && (exm_dest_q != '0) && (exm_dest_q == idex_rs_q))
         fwd_a = 2'b10;
      else if (mwb_wb_q[1] && (mwb_dest_q != '0) && (mwb_dest_q == idex_rs_q))
         fwd_a = 2'b01;
      fwd_b = 2'b00;
      if (exm_wb_q[1] && (exm_dest_q != '0) && (exm_dest_q == idex_rt_q))
         fwd_b = 2'b10;
      else if (mwb_wb_q[1] && (mwb_dest_q != '0) && (mwb_dest_q == idex_rt_q))
         fwd_b = 2'b01;
   end

   assign ex_ctrl  = idex_ex_q;
   assign ex_aluop = idex_aop_q;
   assign mem_ctrl = exm_m_q;
   assign wb_ctrl  = mwb_wb_q;
   assign wb_dest  = mwb_dest_q;

endmodule

// File: tb/tb_ctrl_pipeline.sv
// Directed bench for ctrl_pipeline: reset, forwarding, load-use, branch,
// jump, priority and $0 cases with hand-computed expectations.
module tb_ctrl_pipeline;

   logic       clk, rst;
   logic [1:0] id_ex;
   logic [2:0] id_m, id_wb;
   logic [3:0] id_aluop;
   logic [4:0] id_rs, id_rt, id_rd;
   logic       ex_zero;
   logic [1:0] ex_ctrl, fwd_a, fwd_b;
   logic [3:0] ex_aluop;
   logic [2:0] mem_ctrl, wb_ctrl;
   logic       pc_src, stall, flush;
   logic [4:0] wb_dest;

   int checks = 0;
   int errors = 0;

   ctrl_pipeline #(.RA_W(5), .AOP_W(4)) dut (
      .clk(clk), .rst(rst),
      .id_ex(id_ex), .id_m(id_m), .id_wb(id_wb), .id_aluop(id_aluop),
      .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .ex_zero(ex_zero),
      .ex_ctrl(ex_ctrl), .ex_aluop(ex_aluop), .fwd_a(fwd_a), .fwd_b(fwd_b),
      .mem_ctrl(mem_ctrl), .pc_src(pc_src), .wb_ctrl(wb_ctrl),
      .wb_dest(wb_dest), .stall(stall), .flush(flush)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // all outputs concatenated, 24 bits
   function automatic logic [23:0] all_out();
      return {ex_ctrl, ex_aluop, fwd_a, fwd_b, mem_ctrl, pc_src,
              wb_ctrl, wb_dest, stall, flush};
   endfunction

   task automatic drive(input logic [1:0] ex, input logic [2:0] m,
                        input logic [2:0] wb, input logic [3:0] aop,
                        input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd);
      id_ex = ex; id_m = m; id_wb = wb; id_aluop = aop;
      id_rs = rs; id_rt = rt; id_rd = rd;
      #1;
   endtask

   task automatic bubble();
      drive(2'b00, 3'b000, 3'b000, 4'h0, 5'd0, 5'd0, 5'd0);
   endtask

   // one clock edge, outputs sampled 1 time unit later
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // clean pipeline via a short reset pulse away from the edge
   task automatic clear();
      ex_zero = 1'b0;
      bubble();
      rst = 1'b1;
      #1;
      rst = 1'b0;
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      ex_zero = 1'b1;
      drive(2'b11, 3'b111, 3'b011, 4'hf, 5'd1, 5'd2, 5'd3);
      step();
      checks++; if (all_out() !== 24'h0) begin errors++; $display("FAIL reset_hold: got %h exp %h", all_out(), 24'h0); end
      rst = 1'b0;
      drive(2'b01, 3'b000, 3'b010, 4'h2, 5'd1, 5'd2, 5'd3);
      step();
      checks++; if (ex_ctrl !== 2'b01) begin errors++; $display("FAIL reset_first_ex: got %b exp %b", ex_ctrl, 2'b01); end
      step();
      step();
      checks++; if (wb_ctrl !== 3'b010) begin errors++; $display("FAIL reset_prefill_wb: got %b exp %b", wb_ctrl, 3'b010); end
      #2 rst = 1'b1;
      #1;
      checks++; if (all_out() !== 24'h0) begin errors++; $display("FAIL reset_midcycle: got %h exp %h", all_out(), 24'h0); end
      #1 rst = 1'b0;
      drive(2'b10, 3'b000, 3'b000, 4'h5, 5'd0, 5'd0, 5'd0);
      step();
      checks++; if (ex_ctrl !== 2'b10 || ex_aluop !== 4'h5) begin errors++; $display("FAIL reset_release_ex: got %b/%h exp 10/5", ex_ctrl, ex_aluop); end
      checks++; if (mem_ctrl !== 3'b000 || wb_ctrl !== 3'b000) begin errors++; $display("FAIL reset_release_bubbles: got %b/%b exp 000/000", mem_ctrl, wb_ctrl); end
   endtask

   task automatic test_rtype_chain();
      clear();
      drive(2'b01, 3'b000, 3'b010, 4'h2, 5'd1, 5'd2, 5'd3);   // add $3
      step();
      checks++; if (fwd_a !== 2'b00 || fwd_b !== 2'b00) begin errors++; $display("FAIL rt_add_fwd: got %b/%b exp 00/00", fwd_a, fwd_b); end
      drive(2'b01, 3'b000, 3'b010, 4'h6, 5'd3, 5'd4, 5'd6);   // sub $6,$3,$4
      step();
      checks++; if (fwd_a !== 2'b10 || fwd_b !== 2'b00) begin errors++; $display("FAIL rt_sub_fwd: got %b/%b exp 10/00", fwd_a, fwd_b); end
      drive(2'b01, 3'b000, 3'b010, 4'h2, 5'd7, 5'd3, 5'd8);   // $8 = $7 op $3
      step();
      checks++; if (fwd_a !== 2'b00 || fwd_b !== 2'b01) begin errors++; $display("FAIL rt_third_fwd: got %b/%b exp 00/01", fwd_a, fwd_b); end
      checks++; if (wb_ctrl !== 3'b010 || wb_dest !== 5'd3) begin errors++; $display("FAIL rt_wb: got %b/%0d exp 010/3", wb_ctrl, wb_dest); end
      drive(2'b01, 3'b000, 3'b010, 4'h2, 5'd8, 5'd6, 5'd8);   // $8 = $8 op $6
      step();
      checks++; if (fwd_a !== 2'b10 || fwd_b !== 2'b01) begin errors++; $display("FAIL rt_both_fwd: got %b/%b exp 10/01", fwd_a, fwd_b); end
      drive(2'b01, 3'b000, 3'b010, 4'h2, 5'd8, 5'd0, 5'd9);   // reads $8 written twice
      step();
      checks++; if (fwd_a !== 2'b10 || fwd_b !== 2'b00) begin errors++; $display("FAIL rt_exmem_wins: got %b/%b exp 10/00", fwd_a, fwd_b); end
   endtask

   task automatic test_load_use();
      clear();
      drive(2'b10, 3'b001, 3'b011, 4'h0, 5'd1, 5'd5, 5'd0);   // lw $5
      step();
      drive(2'b01, 3'b000, 3'b010, 4'h2, 5'd5, 5'd2, 5'd9);   // uses $5
      checks++; if (stall !== 1'b1 || flush !== 1'b0) begin errors++; $display("FAIL lu_stall: got %b/%b exp 1/0", stall, flush); end
      step();
      checks++; if (ex_ctrl !== 2'b00 || stall !== 1'b0) begin errors++; $display("FAIL lu_bubble: got %b/%b exp 00/0", ex_ctrl, stall); end
      checks++; if (mem_ctrl !== 3'b001) begin errors++; $display("FAIL lu_mem_adv: got %b exp 001", mem_ctrl); end
      step();
      checks++; if (ex_ctrl !== 2'b01 || fwd_a !== 2'b01 || stall !== 1'b0) begin errors++; $display("FAIL lu_fwd: got %b/%b/%b exp 01/01/0", ex_ctrl, fwd_a, stall); end
      checks++; if (wb_ctrl !== 3'b011 || wb_dest !== 5'd5) begin errors++; $display("FAIL lu_wb: got %b/%0d exp 011/5", wb_ctrl, wb_dest); end
   endtask

   task automatic test_branch(input logic zero);
      clear();
      drive(2'b00, 3'b100, 3'b000, 4'h1, 5'd1, 5'd2, 5'd0);   // beq
      step();
      ex_zero = zero;
      drive(2'b01, 3'b000, 3'b010, 4'h2, 5'd3, 5'd4, 5'd5);
      step();
      ex_zero = 1'b0;
      drive(2'b01, 3'b000, 3'b010, 4'h3, 5'd6, 5'd7, 5'd10);
      checks++; if (pc_src !== zero || flush !== zero) begin errors++; $display("FAIL br_resolve_z%0d: got %b/%b exp %b/%b", zero, pc_src, flush, zero, zero); end
      step();
      if (zero) begin
         checks++; if (ex_ctrl !== 2'b00 || ex_aluop !== 4'h0 || mem_ctrl !== 3'b000) begin errors++; $display("FAIL br_bubbles: got %b/%h/%b exp 00/0/000", ex_ctrl, ex_aluop, mem_ctrl); end
         checks++; if (wb_dest !== 5'd2 || pc_src !== 1'b0 || flush !== 1'b0) begin errors++; $display("FAIL br_wb_adv: got %0d/%b/%b exp 2/0/0", wb_dest, pc_src, flush); end
      end else begin
         checks++; if (ex_ctrl !== 2'b01 || ex_aluop !== 4'h3 || mem_ctrl !== 3'b000) begin errors++; $display("FAIL br_nt_flow: got %b/%h/%b exp 01/3/000", ex_ctrl, ex_aluop, mem_ctrl); end
      end
   endtask

   task automatic test_jump();
      clear();
      drive(2'b00, 3'b000, 3'b100, 4'h0, 5'd0, 5'd0, 5'd0);   // j
      step();
      drive(2'b01, 3'b000, 3'b010, 4'h2, 5'd1, 5'd2, 5'd3);
      step();
      step();
      checks++; if (wb_ctrl !== 3'b100 || flush !== 1'b1 || pc_src !== 1'b0) begin errors++; $display("FAIL jmp_resolve: got %b/%b/%b exp 100/1/0", wb_ctrl, flush, pc_src); end
      step();
      checks++; if (ex_ctrl !== 2'b00 || mem_ctrl !== 3'b000 || wb_ctrl !== 3'b000 || flush !== 1'b0) begin errors++; $display("FAIL jmp_bubbles: got %b/%b/%b/%b exp 00/000/000/0", ex_ctrl, mem_ctrl, wb_ctrl, flush); end
   endtask

   task automatic test_priority();
      clear();
      drive(2'b00, 3'b100, 3'b000, 4'h1, 5'd1, 5'd2, 5'd0);   // beq
      step();
      ex_zero = 1'b1;
      drive(2'b10, 3'b001, 3'b011, 4'h0, 5'd1, 5'd5, 5'd0);   // lw $5
      step();
      ex_zero = 1'b0;
      drive(2'b01, 3'b000, 3'b010, 4'h2, 5'd5, 5'd2, 5'd9);   // uses $5
      checks++; if (flush !== 1'b1 || stall !== 1'b0) begin errors++; $display("FAIL pri_flush_over_stall: got %b/%b exp 1/0", flush, stall); end
      step();
      checks++; if (ex_ctrl !== 2'b00 || mem_ctrl !== 3'b000 || stall !== 1'b0) begin errors++; $display("FAIL pri_bubbles: got %b/%b/%b exp 00/000/0", ex_ctrl, mem_ctrl, stall); end
   endtask

   task automatic test_reg_zero();
      clear();
      drive(2'b01, 3'b000, 3'b010, 4'h2, 5'd1, 5'd2, 5'd0);   // add $0
      step();
      drive(2'b10, 3'b001, 3'b011, 4'h0, 5'd1, 5'd0, 5'd0);   // lw $0
      step();
      drive(2'b01, 3'b000, 3'b010, 4'h2, 5'd0, 5'd0, 5'd4);   // reads $0,$0
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL zero_stall: got %b exp 0", stall); end
      step();
      checks++; if (fwd_a !== 2'b00 || fwd_b !== 2'b00) begin errors++; $display("FAIL zero_fwd: got %b/%b exp 00/00", fwd_a, fwd_b); end
   endtask

   initial begin
      rst = 1'b1;
      ex_zero = 1'b0;
      id_ex = '0; id_m = '0; id_wb = '0; id_aluop = '0;
      id_rs = '0; id_rt = '0; id_rd = '0;
      test_reset();
      test_rtype_chain();
      test_load_use();
      test_branch(1'b1);
      test_branch(1'b0);
      test_jump();
      test_priority();
      test_reg_zero();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
